// File: rtl/packet_sink_multi_ch.sv
// Multi-channel packet sink collecting per-channel latency, count and misrouting statistics
// over an IDLE/WARMUP/MEASURE/DONE run. Define SINK_MAXLAT_EN to add per-channel max latency.
module packet_sink_multi_ch #(
  parameter int N_CH      = 4,
  parameter int DEST_W    = 4,
  parameter int TS_W      = 16,
  parameter int LAT_W     = 24,
  parameter int CNT_W     = 16,
  parameter int BASE_PORT = 0,
  parameter int WARMUP    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          pkt_valid,
  input  logic [N_CH*DEST_W-1:0]   pkt_dest,
  input  logic [N_CH*TS_W-1:0]     pkt_ts,
  input  logic [TS_W-1:0]          timestamp,
  input  logic                     start,
  input  logic                     stop,
  output logic [N_CH*LAT_W-1:0]    latency,
  output logic [N_CH*CNT_W-1:0]    pkt_count,
  output logic [N_CH-1:0]          pkt_error,
  output logic [N_CH*DEST_W-1:0]   err_dest,
`ifdef SINK_MAXLAT_EN
  output logic [N_CH*TS_W-1:0]     max_lat,
`endif
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [LAT_W-1:0] LAT_MAX   = {LAT_W{1'b1}};
  localparam logic [15:0]      WARM_LOAD = 16'(WARMUP - 1);

  state_e                   state_q, state_d;
  logic [15:0]              warm_q, warm_d;
  logic [1:0]               rst_sync_q, rst_sync_d;
  logic [N_CH*LAT_W-1:0]    latency_q, latency_d;
  logic [N_CH*CNT_W-1:0]    pkt_count_q, pkt_count_d;
  logic [N_CH-1:0]          pkt_error_q, pkt_error_d;
  logic [N_CH*DEST_W-1:0]   err_dest_q, err_dest_d;
`ifdef SINK_MAXLAT_EN
  logic [N_CH*TS_W-1:0]     max_lat_q, max_lat_d;
`endif

  logic [TS_W-1:0]          one_lat_s  [N_CH];
  logic [LAT_W:0]           lat_sum_s  [N_CH];
  logic [DEST_W-1:0]        exp_dest_s [N_CH];
  logic                     any_sat_s;

  // Per-channel packet latency (modulo wrap), widened accumulator sum and expected destination.
  always_comb begin
    any_sat_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      one_lat_s[i]  = timestamp - pkt_ts[i*TS_W +: TS_W];
      lat_sum_s[i]  = {1'b0, latency_q[i*LAT_W +: LAT_W]} + (LAT_W+1)'(one_lat_s[i]);
      exp_dest_s[i] = DEST_W'(BASE_PORT + i);
      if (pkt_count_q[i*CNT_W +: CNT_W] == CNT_MAX) begin
        any_sat_s = 1'b1;
      end else begin
        any_sat_s = any_sat_s;
      end
    end
  end

  // Reset-release synchroniser: logic runs only once the second stage has seen rst high.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Run FSM and statistics next-state.
  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    latency_d   = latency_q;
    pkt_count_d = pkt_count_q;
    pkt_error_d = pkt_error_q;
    err_dest_d  = err_dest_q;
`ifdef SINK_MAXLAT_EN
    max_lat_d   = max_lat_q;
`endif
    if (!rst_sync_q[1]) begin
      state_d = state_q;
    end else if (start) begin
      // start always wins over stop and over packets in the same cycle
      state_d     = ST_WARMUP;
      warm_d      = WARM_LOAD;
      latency_d   = {(N_CH*LAT_W){1'b0}};
      pkt_count_d = {(N_CH*CNT_W){1'b0}};
      pkt_error_d = {N_CH{1'b0}};
      err_dest_d  = {(N_CH*DEST_W){1'b0}};
`ifdef SINK_MAXLAT_EN
      max_lat_d   = {(N_CH*TS_W){1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_WARMUP: begin
          if (warm_q == 16'd0) begin
            state_d = ST_MEASURE;
          end else begin
            warm_d = warm_q - 16'd1;
          end
        end
        ST_MEASURE: begin
          if (stop || any_sat_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_MEASURE;
          end
        end
        ST_DONE:    state_d = ST_DONE;
        default:    state_d = ST_IDLE;
      endcase

      for (int i = 0; i < N_CH; i++) begin
        if ((state_q != ST_IDLE) && pkt_valid[i] &&
            (pkt_dest[i*DEST_W +: DEST_W] != exp_dest_s[i])) begin
          pkt_error_d[i] = 1'b1;
          if (!pkt_error_q[i]) begin
            err_dest_d[i*DEST_W +: DEST_W] = pkt_dest[i*DEST_W +: DEST_W];
          end else begin
            err_dest_d[i*DEST_W +: DEST_W] = err_dest_q[i*DEST_W +: DEST_W];
          end
        end else begin
          pkt_error_d[i] = pkt_error_q[i];
        end

        if ((state_q == ST_MEASURE) && pkt_valid[i]) begin
          if (pkt_count_q[i*CNT_W +: CNT_W] != CNT_MAX) begin
            pkt_count_d[i*CNT_W +: CNT_W] = pkt_count_q[i*CNT_W +: CNT_W] + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            pkt_count_d[i*CNT_W +: CNT_W] = CNT_MAX;
          end
          if (lat_sum_s[i][LAT_W]) begin
            latency_d[i*LAT_W +: LAT_W] = LAT_MAX;
          end else begin
            latency_d[i*LAT_W +: LAT_W] = lat_sum_s[i][LAT_W-1:0];
          end
`ifdef SINK_MAXLAT_EN
          if (one_lat_s[i] > max_lat_q[i*TS_W +: TS_W]) begin
            max_lat_d[i*TS_W +: TS_W] = one_lat_s[i];
          end else begin
            max_lat_d[i*TS_W +: TS_W] = max_lat_q[i*TS_W +: TS_W];
          end
`endif
        end else begin
          pkt_count_d[i*CNT_W +: CNT_W] = pkt_count_q[i*CNT_W +: CNT_W];
        end
      end
    end
  end

  // State and statistics registers; rst low clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q  <= 2'b00;
      state_q     <= ST_IDLE;
      warm_q      <= 16'd0;
      latency_q   <= {(N_CH*LAT_W){1'b0}};
      pkt_count_q <= {(N_CH*CNT_W){1'b0}};
      pkt_error_q <= {N_CH{1'b0}};
      err_dest_q  <= {(N_CH*DEST_W){1'b0}};
`ifdef SINK_MAXLAT_EN
      max_lat_q   <= {(N_CH*TS_W){1'b0}};
`endif
    end else begin
      rst_sync_q  <= rst_sync_d;
      state_q     <= state_d;
      warm_q      <= warm_d;
      latency_q   <= latency_d;
      pkt_count_q <= pkt_count_d;
      pkt_error_q <= pkt_error_d;
      err_dest_q  <= err_dest_d;
`ifdef SINK_MAXLAT_EN
      max_lat_q   <= max_lat_d;
`endif
    end
  end

  assign latency   = latency_q;
  assign pkt_count = pkt_count_q;
  assign pkt_error = pkt_error_q;
  assign err_dest  = err_dest_q;
  assign state     = state_q;
`ifdef SINK_MAXLAT_EN
  assign max_lat   = max_lat_q;
`endif

endmodule
